decode_stage_pipe: RTL and testbench

- Pipelined decode stage for the 16-bit WISC core.
- Holds the 8-entry general register file (width DATA_W).
- Forms the immediate and destination register from control fields supplied by the existing control unit.
- Detects load-use hazards and registers everything into an ID/EX pipeline register.
- Sits between fetch (IF/ID) and execute. Adds write-back bypass, flush, back-pressure and a stall counter.

---
 rtl/decode_stage_pipe_if.sv | 53 +++++
 rtl/decode_stage_pipe.sv | 180 ++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pipe_if.sv
// rtl/decode_stage_pipe_if.sv - signal bundle between fetch/control/write-back and the decode stage
//
// Purpose: groups every non-clock, non-reset signal of decode_stage_pipe.
// Ports (slave = decode stage view):
//   inputs : if_valid, if_instr, if_pc, ctl_regDst, ctl_sign_extd, ctl_regWrite,
//            ctl_memRead, ctl_err, flush, ex_stall, wb_en, wb_reg, wb_data
//   outputs: stall_out, id_valid, id_instr, id_pc, id_rs_data, id_rt_data, id_imm,
//            id_wr_reg, id_reg_write, id_mem_read, id_err, stall_count
interface decode_stage_pipe_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              if_valid;
    logic [15:0]       if_instr;
    logic [DATA_W-1:0] if_pc;
    logic [1:0]        ctl_regDst;
    logic [1:0]        ctl_sign_extd;
    logic              ctl_regWrite;
    logic              ctl_memRead;
    logic              ctl_err;
    logic              flush;
    logic              ex_stall;
    logic              wb_en;
    logic [2:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;

    logic              stall_out;
    logic              id_valid;
    logic [15:0]       id_instr;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [2:0]        id_wr_reg;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_err;
    logic [CNT_W-1:0]  stall_count;

    modport slave (
        input  if_valid, if_instr, if_pc, ctl_regDst, ctl_sign_extd, ctl_regWrite,
               ctl_memRead, ctl_err, flush, ex_stall, wb_en, wb_reg, wb_data,
        output stall_out, id_valid, id_instr, id_pc, id_rs_data, id_rt_data, id_imm,
               id_wr_reg, id_reg_write, id_mem_read, id_err, stall_count
    );

    modport master (
        output if_valid, if_instr, if_pc, ctl_regDst, ctl_sign_extd, ctl_regWrite,
               ctl_memRead, ctl_err, flush, ex_stall, wb_en, wb_reg, wb_data,
        input  stall_out, id_valid, id_instr, id_pc, id_rs_data, id_rt_data, id_imm,
               id_wr_reg, id_reg_write, id_mem_read, id_err, stall_count
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - WISC decode stage: register file, immediate/dest forming, load-use hazard, ID/EX register
//
// Purpose: decodes the IF/ID instruction into the ID/EX pipeline register.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (register file, ID/EX and stall counter clear)
//   bus  - decode_stage_pipe_if.slave: IF/ID + control inputs, write-back port,
//          flush/ex_stall, ID/EX outputs, stall_out and stall_count
module decode_stage_pipe #(
    parameter int DATA_W    = 16,
    parameter int BYPASS_EN = 1,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_stage_pipe_if.slave    bus
);

    logic [DATA_W-1:0] rf_q [8];
    logic [DATA_W-1:0] rf_d [8];

    logic              valid_q,     valid_d;
    logic [15:0]       instr_q,     instr_d;
    logic [DATA_W-1:0] pc_q,        pc_d;
    logic [DATA_W-1:0] rs_data_q,   rs_data_d;
    logic [DATA_W-1:0] rt_data_q,   rt_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [2:0]        wr_reg_q,    wr_reg_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              err_q,       err_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    logic [2:0]        rs_idx;
    logic [2:0]        rt_idx;
    logic [DATA_W-1:0] rs_rd;
    logic [DATA_W-1:0] rt_rd;
    logic [DATA_W-1:0] imm_dec;
    logic [2:0]        wr_dec;
    logic              hz;
    logic              stall;

    assign rs_idx = bus.if_instr[10:8];
    assign rt_idx = bus.if_instr[7:5];

    // Register file write: unconditional on wb_en, independent of stall/flush.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (bus.wb_en) begin
            rf_d[bus.wb_reg] = bus.wb_data;
        end
    end

    // Read ports, with optional forwarding of the write-back happening this cycle.
    always_comb begin
        rs_rd = rf_q[rs_idx];
        rt_rd = rf_q[rt_idx];
        if (BYPASS_EN != 0 && bus.wb_en && bus.wb_reg == rs_idx) begin
            rs_rd = bus.wb_data;
        end
        if (BYPASS_EN != 0 && bus.wb_en && bus.wb_reg == rt_idx) begin
            rt_rd = bus.wb_data;
        end
    end

    always_comb begin
        imm_dec = '0;
        case (bus.ctl_sign_extd)
            2'b00:   imm_dec = {{(DATA_W-5){bus.if_instr[4]}},  bus.if_instr[4:0]};
            2'b01:   imm_dec = {{(DATA_W-8){bus.if_instr[7]}},  bus.if_instr[7:0]};
            2'b10:   imm_dec = {{(DATA_W-5){1'b0}},             bus.if_instr[4:0]};
            default: imm_dec = {{(DATA_W-11){bus.if_instr[10]}}, bus.if_instr[10:0]};
        endcase
    end

    always_comb begin
        wr_dec = 3'd0;
        case (bus.ctl_regDst)
            2'b00:   wr_dec = bus.if_instr[10:8];
            2'b01:   wr_dec = bus.if_instr[4:2];
            2'b10:   wr_dec = 3'b111;
            default: wr_dec = bus.if_instr[7:5];
        endcase
    end

    // Both source fields are compared even when the instruction does not read
    // them; an occasional spurious bubble is cheaper than per-opcode decode here.
    assign hz = (HAZARD_EN != 0) & bus.if_valid & valid_q & mem_read_q & reg_write_q &
                ((wr_reg_q == rs_idx) | (wr_reg_q == rt_idx));

    // Flush wins so fetch can redirect even while execute is stalled.
    assign stall = ~bus.flush & (bus.ex_stall | hz);

    always_comb begin
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        wr_reg_d    = wr_reg_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        if (bus.flush || (!bus.ex_stall && hz)) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            err_d       = 1'b0;
        end else if (!bus.ex_stall) begin
            valid_d     = bus.if_valid;
            instr_d     = bus.if_instr;
            pc_d        = bus.if_pc;
            rs_data_d   = rs_rd;
            rt_data_d   = rt_rd;
            imm_d       = imm_dec;
            wr_reg_d    = wr_dec;
            reg_write_d = bus.ctl_regWrite & bus.if_valid;
            mem_read_d  = bus.ctl_memRead  & bus.if_valid;
            err_d       = bus.ctl_err      & bus.if_valid;
        end

        if (stall && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
            valid_q     <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            wr_reg_q    <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= rf_d[i];
            end
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            wr_reg_q    <= wr_reg_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.stall_out    = stall;
    assign bus.id_valid     = valid_q;
    assign bus.id_instr     = instr_q;
    assign bus.id_pc        = pc_q;
    assign bus.id_rs_data   = rs_data_q;
    assign bus.id_rt_data   = rt_data_q;
    assign bus.id_imm       = imm_q;
    assign bus.id_wr_reg    = wr_reg_q;
    assign bus.id_reg_write = reg_write_q;
    assign bus.id_mem_read  = mem_read_q;
    assign bus.id_err       = err_q;
    assign bus.stall_count  = cnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - directed table-driven bench for decode_stage_pipe
module tb_decode_stage_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_pipe_if #(.DATA_W(16), .CNT_W(16)) a ();
    decode_stage_pipe_if #(.DATA_W(16), .CNT_W(2))  b ();

    decode_stage_pipe #(.DATA_W(16), .BYPASS_EN(1), .HAZARD_EN(1), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    decode_stage_pipe #(.DATA_W(16), .BYPASS_EN(0), .HAZARD_EN(1), .CNT_W(2)) u_dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    // Second instance (no bypass, 2-bit counter) sees identical stimulus.
    assign b.if_valid      = a.if_valid;
    assign b.if_instr      = a.if_instr;
    assign b.if_pc         = a.if_pc;
    assign b.ctl_regDst    = a.ctl_regDst;
    assign b.ctl_sign_extd = a.ctl_sign_extd;
    assign b.ctl_regWrite  = a.ctl_regWrite;
    assign b.ctl_memRead   = a.ctl_memRead;
    assign b.ctl_err       = a.ctl_err;
    assign b.flush         = a.flush;
    assign b.ex_stall      = a.ex_stall;
    assign b.wb_en         = a.wb_en;
    assign b.wb_reg        = a.wb_reg;
    assign b.wb_data       = a.wb_data;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic [1:0] dst,
                         input logic [1:0] sx, input logic rw, input logic mr, input logic er);
        a.if_valid      = v;
        a.if_instr      = instr;
        a.ctl_regDst    = dst;
        a.ctl_sign_extd = sx;
        a.ctl_regWrite  = rw;
        a.ctl_memRead   = mr;
        a.ctl_err       = er;
    endtask

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    typedef struct {
        logic        v;
        logic [15:0] instr;
        logic [1:0]  dst;
        logic [1:0]  sx;
        logic        rw;
        logic        er;
        logic [15:0] exp_imm;
        logic [2:0]  exp_wr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 16'h07F0, 2'b00, 2'b00, 1'b1, 1'b0, 16'hFFF0, 3'd7};
        vecs[1] = '{1'b1, 16'h07F0, 2'b01, 2'b01, 1'b1, 1'b0, 16'hFFF0, 3'd4};
        vecs[2] = '{1'b1, 16'h07F0, 2'b10, 2'b10, 1'b0, 1'b0, 16'h0010, 3'd7};
        vecs[3] = '{1'b1, 16'h07F0, 2'b11, 2'b11, 1'b1, 1'b1, 16'hFFF0, 3'd7};
        vecs[4] = '{1'b1, 16'h0578, 2'b00, 2'b00, 1'b1, 1'b0, 16'hFFF8, 3'd5};
        vecs[5] = '{1'b0, 16'h0578, 2'b01, 2'b01, 1'b1, 1'b1, 16'h0078, 3'd6};
        vecs[6] = '{1'b1, 16'h0578, 2'b11, 2'b10, 1'b1, 1'b0, 16'h0018, 3'd3};
        vecs[7] = '{1'b1, 16'h0578, 2'b10, 2'b11, 1'b1, 1'b0, 16'hFD78, 3'd7};
        vecs[8] = '{1'b1, 16'h0312, 2'b00, 2'b11, 1'b0, 1'b1, 16'h0312, 3'd3};
        vecs[9] = '{1'b1, 16'h0000, 2'b01, 2'b00, 1'b1, 1'b0, 16'h0000, 3'd0};

        drive(1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        a.if_pc = '0; a.flush = 1'b0; a.ex_stall = 1'b0;
        a.wb_en = 1'b0; a.wb_reg = '0; a.wb_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_valid", {31'd0, a.id_valid}, 0);
        chk("rst_id_instr", {16'd0, a.id_instr}, 0);
        chk("rst_id_imm", {16'd0, a.id_imm}, 0);
        chk("rst_stall_count", {16'd0, a.stall_count}, 0);
        chk("rst_qualifiers", {29'd0, a.id_reg_write, a.id_mem_read, a.id_err}, 0);
        rst = 1'b0;

        // Immediate / destination / qualifier table
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].instr, vecs[i].dst, vecs[i].sx, vecs[i].rw, 1'b0, vecs[i].er);
            a.if_pc = 16'h0100 + 16'(2 * i);
            step();
            chk($sformatf("tbl%0d_imm", i), {16'd0, a.id_imm}, {16'd0, vecs[i].exp_imm});
            chk($sformatf("tbl%0d_wr", i), {29'd0, a.id_wr_reg}, {29'd0, vecs[i].exp_wr});
            chk($sformatf("tbl%0d_valid", i), {31'd0, a.id_valid}, {31'd0, vecs[i].v});
            chk($sformatf("tbl%0d_rw", i), {31'd0, a.id_reg_write}, {31'd0, vecs[i].rw & vecs[i].v});
            chk($sformatf("tbl%0d_err", i), {31'd0, a.id_err}, {31'd0, vecs[i].er & vecs[i].v});
            chk($sformatf("tbl%0d_pc", i), {16'd0, a.id_pc}, 32'h0100 + 32'(2 * i));
        end

        // Write R3 then read it through rs
        drive(1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        a.wb_en = 1'b1; a.wb_reg = 3'd3; a.wb_data = 16'h1234;
        step();
        a.wb_reg = 3'd2; a.wb_data = 16'h1111;
        step();
        a.wb_en = 1'b0;
        drive(1'b1, 16'h0300, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step();
        chk("rf_r3_rs", {16'd0, a.id_rs_data}, 32'h1234);

        // Same-cycle bypass on rt=2
        a.wb_en = 1'b1; a.wb_reg = 3'd2; a.wb_data = 16'hBEEF;
        drive(1'b1, 16'h0040, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step();
        a.wb_en = 1'b0;
        chk("bypass_rt", {16'd0, a.id_rt_data}, 32'hBEEF);
        chk("nobypass_rt", {16'd0, b.id_rt_data}, 32'h1111);

        // Load into R5, dependent reader of R5: one bubble
        drive(1'b1, 16'h0500, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        #1;
        chk("load_no_stall", {31'd0, a.stall_out}, 0);
        step();
        chk("load_id_mem_read", {31'd0, a.id_mem_read}, 1);
        chk("load_id_wr", {29'd0, a.id_wr_reg}, 5);
        drive(1'b1, 16'h00A0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("hz_stall_out", {31'd0, a.stall_out}, 1);
        step();
        exp_cnt++;
        chk("hz_bubble_valid", {31'd0, a.id_valid}, 0);
        chk("hz_bubble_rw", {31'd0, a.id_reg_write}, 0);
        chk("hz_stall_count", {16'd0, a.stall_count}, exp_cnt);
        chk("hz_cleared", {31'd0, a.stall_out}, 0);
        step();
        chk("hz_issue_valid", {31'd0, a.id_valid}, 1);
        chk("hz_issue_instr", {16'd0, a.id_instr}, 32'h00A0);
        chk("nb_count_1", {30'd0, b.stall_count}, sat3(exp_cnt));

        // ex_stall held for three cycles
        drive(1'b1, 16'h0123, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        a.ex_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("exs%0d_stall_out", c), {31'd0, a.stall_out}, 1);
            step();
            exp_cnt++;
            chk($sformatf("exs%0d_hold_instr", c), {16'd0, a.id_instr}, 32'h00A0);
            chk($sformatf("exs%0d_hold_valid", c), {31'd0, a.id_valid}, 1);
        end
        a.ex_stall = 1'b0;
        step();
        chk("exs_release_instr", {16'd0, a.id_instr}, 32'h0123);
        chk("exs_stall_count", {16'd0, a.stall_count}, exp_cnt);
        chk("nb_count_sat", {30'd0, b.stall_count}, sat3(exp_cnt));

        // Flush coincident with hazard and ex_stall
        drive(1'b1, 16'h0500, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h00A0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        a.ex_stall = 1'b1; a.flush = 1'b1;
        #1;
        chk("flush_stall_out", {31'd0, a.stall_out}, 0);
        step();
        a.ex_stall = 1'b0; a.flush = 1'b0;
        chk("flush_valid", {31'd0, a.id_valid}, 0);
        chk("flush_qualifiers", {29'd0, a.id_reg_write, a.id_mem_read, a.id_err}, 0);
        chk("flush_count", {16'd0, a.stall_count}, exp_cnt);

        // Asynchronous reset mid-stream
        drive(1'b1, 16'h0300, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
        step();
        chk("pre_arst_rs", {16'd0, a.id_rs_data}, 32'h1234);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, a.id_valid}, 0);
        chk("arst_instr", {16'd0, a.id_instr}, 0);
        chk("arst_rs", {16'd0, a.id_rs_data}, 0);
        chk("arst_count", {16'd0, a.stall_count}, 0);
        chk("arst_nb_count", {30'd0, b.stall_count}, 0);
        rst = 1'b0;
        step();
        chk("post_arst_valid", {31'd0, a.id_valid}, 1);
        chk("post_arst_r3_cleared", {16'd0, a.id_rs_data}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
